// File: rtl/alu_seq_fsm.sv
// alu_seq_fsm: sequencer and datapath for the arithmetic instructions (add, mul, div, nand).
// It fetches operands b and c from the register file, executes the operation, and
// writes the result back to register a.
//
// Ports
//   clk        system clock, rising edge
//   init       asynchronous active-high reset
//   en         level enable, held by the control unit for the whole instruction
//   op         00 add, 01 mul, 10 div, 11 nand; sampled in SEL_B
//   reg_a/b/c  destination / first operand / second operand register indices
//   reg_rdata  register file read data, valid one cycle after reg_sel is applied
//   reg_sel    register select
//   reg_we     register write enable; high only in WRITE_A
//   reg_wdata  write-back data
//   finished   instruction complete; held high while in FIN
//   div_zero   sticky divide-by-zero flag, cleared on entry to SEL_B
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for en
// SEL_B   | select operand b, latch op, clear div_zero
// SEL_C   | select operand c, capture b into x
// LOAD_C  | capture c into y, prime counter and accumulator, detect x/0
// EXEC    | single-cycle add/nand/fast mul, or iterative mul/div
// WRITE_A | drive acc to register a (suppressed on divide by zero)
// FIN     | finished held high until en drops
module alu_seq_fsm #(
   parameter int WIDTH     = 32,
   parameter int REG_SEL_W = 3,
   parameter int FAST_MUL  = 0
) (
   input  logic                 clk,
   input  logic                 init,
   input  logic                 en,
   input  logic [1:0]           op,
   input  logic [REG_SEL_W-1:0] reg_a,
   input  logic [REG_SEL_W-1:0] reg_b,
   input  logic [REG_SEL_W-1:0] reg_c,
   input  logic [WIDTH-1:0]     reg_rdata,
   output logic [REG_SEL_W-1:0] reg_sel,
   output logic                 reg_we,
   output logic [WIDTH-1:0]     reg_wdata,
   output logic                 finished,
   output logic                 div_zero
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_MUL  = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b10;
   localparam logic [1:0] OP_NAND = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SEL_B   = 3'd1,
      SEL_C   = 3'd2,
      LOAD_C  = 3'd3,
      EXEC    = 3'd4,
      WRITE_A = 3'd5,
      FIN     = 3'd6
   } state_t;

   state_t           state;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] rem;
   logic [CNT_W-1:0] cnt;

   // Restoring divide step: shift the next dividend bit into the partial
   // remainder and subtract the divisor when it fits. One bit wider than
   // WIDTH, because the shifted remainder can reach 2*divisor-1.
   logic [WIDTH:0] div_trial;
   logic [WIDTH:0] div_diff;
   logic           div_fits;

   always_comb begin
      div_trial = {rem, x[WIDTH-1]};
      div_diff  = div_trial - {1'b0, y};
      div_fits  = (div_trial >= {1'b0, y});
   end

   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         state    <= IDLE;
         op_q     <= OP_ADD;
         x        <= '0;
         y        <= '0;
         acc      <= '0;
         rem      <= '0;
         cnt      <= '0;
         div_zero <= 1'b0;
      end else if (!en) begin
         // Dropping en abandons any instruction in flight, including one
         // partway through an iterative multiply or divide.
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               state    <= SEL_B;
               div_zero <= 1'b0;
            end
            SEL_B: begin
               op_q  <= op;
               state <= SEL_C;
            end
            SEL_C: begin
               x     <= reg_rdata;
               state <= LOAD_C;
            end
            LOAD_C: begin
               y   <= reg_rdata;
               cnt <= CNT_W'(WIDTH - 1);
               acc <= '0;
               rem <= '0;
               if (op_q == OP_DIV && reg_rdata == '0) begin
                  div_zero <= 1'b1;
                  state    <= WRITE_A;
               end else begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               case (op_q)
                  OP_ADD: begin
                     acc   <= x + y;
                     state <= WRITE_A;
                  end
                  OP_NAND: begin
                     acc   <= ~(x & y);
                     state <= WRITE_A;
                  end
                  OP_MUL: begin
                     if (FAST_MUL != 0) begin
                        acc   <= x * y;
                        state <= WRITE_A;
                     end else begin
                        if (y[0]) acc <= acc + x;
                        x <= x << 1;
                        y <= y >> 1;
                        if (cnt == '0) state <= WRITE_A;
                        else cnt <= cnt - 1'b1;
                     end
                  end
                  default: begin
                     // The dividend is shifted out of x MSB first, and the
                     // quotient is shifted into acc from the bottom.
                     x   <= x << 1;
                     rem <= div_fits ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
                     acc <= {acc[WIDTH-2:0], div_fits};
                     if (cnt == '0) state <= WRITE_A;
                     else cnt <= cnt - 1'b1;
                  end
               endcase
            end
            WRITE_A: state <= FIN;
            FIN:     state <= FIN;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      case (state)
         SEL_B:   reg_sel = reg_b;
         SEL_C:   reg_sel = reg_c;
         WRITE_A: reg_sel = reg_a;
         default: reg_sel = '0;
      endcase
      reg_we    = (state == WRITE_A) && !div_zero;
      reg_wdata = acc;
      finished  = (state == FIN);
   end

endmodule

// File: tb/tb_alu_seq_fsm.sv
module tb_alu_seq_fsm;

   logic        clk = 1'b0;
   logic        init = 1'b1;
   logic        en0 = 1'b0;
   logic        en1 = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [2:0]  ra = '0, rb = '0, rc = '0;

   logic [2:0]  sel0, sel1;
   logic        we0, we1, fin0, fin1, dz0, dz1;
   logic [31:0] wd0, wd1, rd0, rd1;

   logic [31:0] mem0 [8];
   logic [31:0] mem1 [8];
   logic        pl_we0 = 1'b0, pl_we1 = 1'b0;
   logic [2:0]  pl_idx = '0;
   logic [31:0] pl_dat = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_seq_fsm #(.WIDTH(32), .REG_SEL_W(3), .FAST_MUL(0)) dut0 (
      .clk(clk), .init(init), .en(en0), .op(op),
      .reg_a(ra), .reg_b(rb), .reg_c(rc), .reg_rdata(rd0),
      .reg_sel(sel0), .reg_we(we0), .reg_wdata(wd0),
      .finished(fin0), .div_zero(dz0));

   alu_seq_fsm #(.WIDTH(32), .REG_SEL_W(3), .FAST_MUL(1)) dut1 (
      .clk(clk), .init(init), .en(en1), .op(op),
      .reg_a(ra), .reg_b(rb), .reg_c(rc), .reg_rdata(rd1),
      .reg_sel(sel1), .reg_we(we1), .reg_wdata(wd1),
      .finished(fin1), .div_zero(dz1));

   // Register files: registered read, write at the clock edge.
   always @(posedge clk) begin
      rd0 <= mem0[sel0];
      rd1 <= mem1[sel1];
      if (we0) mem0[sel0] <= wd0;
      if (we1) mem1[sel1] <= wd1;
      if (pl_we0) mem0[pl_idx] <= pl_dat;
      if (pl_we1) mem1[pl_idx] <= pl_dat;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic preload(input bit d, input logic [2:0] idx, input logic [31:0] val);
      @(negedge clk);
      pl_idx = idx;
      pl_dat = val;
      if (d) pl_we1 = 1'b1;
      else   pl_we0 = 1'b1;
      @(negedge clk);
      pl_we0 = 1'b0;
      pl_we1 = 1'b0;
   endtask

   // Runs one instruction; cycle 1 is the cycle after the IDLE->SEL_B edge.
   task automatic run(input bit d, input logic [1:0] o, input logic [1:0] o_late,
                      input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                      output int lat, output int wes, output logic dz_c1, output logic dz_fin);
      @(negedge clk);
      op = o; ra = a; rb = b; rc = c;
      if (d) en1 = 1'b1;
      else   en0 = 1'b1;
      lat = -1; wes = 0; dz_c1 = 1'bx; dz_fin = 1'bx;
      for (int cyc = 1; cyc <= 100 && lat < 0; cyc++) begin
         @(negedge clk);
         if (cyc == 1) dz_c1 = d ? dz1 : dz0;
         if (cyc == 2) op = o_late;
         if (d ? we1 : we0) wes++;
         if (d ? fin1 : fin0) begin
            lat    = cyc;
            dz_fin = d ? dz1 : dz0;
         end
      end
      en0 = 1'b0;
      en1 = 1'b0;
      @(negedge clk);
   endtask

   // Starts an instruction on dut0 and kills it at stop_cyc, by en or by init.
   task automatic abort_run(input bit use_init, input logic [1:0] o,
                            input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                            input int stop_cyc);
      int wes;
      @(negedge clk);
      op = o; ra = a; rb = b; rc = c;
      en0 = 1'b1;
      for (int cyc = 1; cyc <= stop_cyc; cyc++) @(negedge clk);
      if (use_init) begin
         #1 init = 1'b1;
         #1;
         check("init_wdata", wd0, 32'h0);
         check("init_we", {31'b0, we0}, 32'h0);
         check("init_fin", {31'b0, fin0}, 32'h0);
         check("init_sel", {29'b0, sel0}, 32'h0);
         check("init_dz", {31'b0, dz0}, 32'h0);
         en0 = 1'b0;
         #1 init = 1'b0;
      end else begin
         en0 = 1'b0;
         @(posedge clk);
         #1;
         check("abort_fin", {31'b0, fin0}, 32'h0);
         check("abort_we", {31'b0, we0}, 32'h0);
         check("abort_sel", {29'b0, sel0}, 32'h0);
      end
      wes = 0;
      repeat (45) begin
         @(negedge clk);
         if (we0) wes++;
      end
      check(use_init ? "init_nowrite" : "abort_nowrite", 32'(wes), 32'h0);
   endtask

   initial begin
      int lat, wes;
      logic dzc1, dzf;

      for (int i = 0; i < 8; i++) begin
         mem0[i] = '0;
         mem1[i] = '0;
      end

      repeat (2) @(negedge clk);
      check("rst_fin", {31'b0, fin0}, 32'h0);
      check("rst_we", {31'b0, we0}, 32'h0);
      check("rst_dz", {31'b0, dz0}, 32'h0);
      check("rst_sel", {29'b0, sel0}, 32'h0);
      check("rst_wdata", wd0, 32'h0);
      init = 1'b0;

      // add with wrap: FFFFFFFF + 2
      preload(0, 3'd1, 32'hFFFF_FFFF);
      preload(0, 3'd2, 32'h0000_0002);
      run(0, 2'b00, 2'b00, 3'd3, 3'd1, 3'd2, lat, wes, dzc1, dzf);
      check("add_res", mem0[3], 32'h0000_0001);
      check("add_lat", 32'(lat), 32'd6);
      check("add_we", 32'(wes), 32'd1);

      // iterative multiply
      preload(0, 3'd1, 32'h0001_0001);
      preload(0, 3'd2, 32'h0001_0001);
      run(0, 2'b01, 2'b01, 3'd3, 3'd1, 3'd2, lat, wes, dzc1, dzf);
      check("mul_res", mem0[3], 32'h0002_0001);
      check("mul_lat", 32'(lat), 32'd37);
      check("mul_we", 32'(wes), 32'd1);

      // fast multiply
      preload(1, 3'd1, 32'h0001_0001);
      preload(1, 3'd2, 32'h0001_0001);
      run(1, 2'b01, 2'b01, 3'd3, 3'd1, 3'd2, lat, wes, dzc1, dzf);
      check("fmul_res", mem1[3], 32'h0002_0001);
      check("fmul_lat", 32'(lat), 32'd6);

      // divide 100/7
      preload(0, 3'd1, 32'd100);
      preload(0, 3'd2, 32'd7);
      run(0, 2'b10, 2'b10, 3'd3, 3'd1, 3'd2, lat, wes, dzc1, dzf);
      check("div_res", mem0[3], 32'd14);
      check("div_lat", 32'(lat), 32'd37);
      check("div_dz", {31'b0, dzf}, 32'h0);

      // divide by zero: no write, r3 keeps 14
      preload(0, 3'd2, 32'd0);
      run(0, 2'b10, 2'b10, 3'd3, 3'd1, 3'd2, lat, wes, dzc1, dzf);
      check("dz_flag", {31'b0, dzf}, 32'h1);
      check("dz_we", 32'(wes), 32'd0);
      check("dz_r3", mem0[3], 32'd14);
      check("dz_lat", 32'(lat), 32'd5);
      check("dz_sticky", {31'b0, dz0}, 32'h1);

      // nand with full aliasing; op switched to add after SEL_B must be ignored
      preload(0, 3'd4, 32'hF0F0_F0F0);
      run(0, 2'b11, 2'b00, 3'd4, 3'd4, 3'd4, lat, wes, dzc1, dzf);
      check("dz_clear", {31'b0, dzc1}, 32'h0);
      check("nand_res", mem0[4], 32'h0F0F_0F0F);
      check("nand_lat", 32'(lat), 32'd6);

      // 0/x, x/1, max/max
      preload(0, 3'd5, 32'd0);
      preload(0, 3'd6, 32'd9);
      preload(0, 3'd7, 32'hAAAA_AAAA);
      run(0, 2'b10, 2'b10, 3'd7, 3'd5, 3'd6, lat, wes, dzc1, dzf);
      check("div_0x", mem0[7], 32'd0);
      preload(0, 3'd5, 32'h1234_5678);
      preload(0, 3'd6, 32'd1);
      run(0, 2'b10, 2'b10, 3'd7, 3'd5, 3'd6, lat, wes, dzc1, dzf);
      check("div_x1", mem0[7], 32'h1234_5678);
      preload(0, 3'd5, 32'hFFFF_FFFF);
      preload(0, 3'd6, 32'hFFFF_FFFF);
      run(0, 2'b10, 2'b10, 3'd7, 3'd5, 3'd6, lat, wes, dzc1, dzf);
      check("div_maxmax", mem0[7], 32'd1);

      // iterative multiply overflow wraps: 0x10000 * 0x10003 -> 0x30000
      preload(0, 3'd5, 32'h0001_0000);
      preload(0, 3'd6, 32'h0001_0003);
      run(0, 2'b01, 2'b01, 3'd7, 3'd5, 3'd6, lat, wes, dzc1, dzf);
      check("mul_wrap", mem0[7], 32'h0003_0000);

      // abort divide by dropping en in cycle 10
      preload(0, 3'd1, 32'd100);
      preload(0, 3'd2, 32'd7);
      preload(0, 3'd3, 32'h0000_DEAD);
      abort_run(1'b0, 2'b10, 3'd3, 3'd1, 3'd2, 10);
      check("abort_r3", mem0[3], 32'h0000_DEAD);
      preload(0, 3'd2, 32'd5);
      run(0, 2'b00, 2'b00, 3'd3, 3'd1, 3'd2, lat, wes, dzc1, dzf);
      check("post_abort_add", mem0[3], 32'd105);
      check("post_abort_lat", 32'(lat), 32'd6);

      // asynchronous init mid-EXEC of an iterative multiply
      preload(0, 3'd1, 32'h0001_0001);
      preload(0, 3'd2, 32'h0001_0001);
      preload(0, 3'd3, 32'h0000_BEEF);
      abort_run(1'b1, 2'b01, 3'd3, 3'd1, 3'd2, 8);
      check("init_r3", mem0[3], 32'h0000_BEEF);
      run(0, 2'b00, 2'b00, 3'd3, 3'd1, 3'd2, lat, wes, dzc1, dzf);
      check("post_init_add", mem0[3], 32'h0002_0002);
      check("post_init_lat", 32'(lat), 32'd6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
